secuenciador_mult: RTL and testbench
====================================

SECUENCIADOR_MULT -- requirements
Module: secuenciador_mult

Interface
REQ-001 SHALL have parameter NUM_BITS, default 4, operand width in bits (two's complement).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, operand-pair buffer entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles waited for fin after start.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  upstream offers an operand pair.
REQ-007 SHALL have port in_ready  out  1  buffer can accept a pair.
REQ-008 SHALL have port in_multiplicando  in  NUM_BITS  signed multiplicand.
REQ-009 SHALL have port in_multiplicador  in  NUM_BITS  signed multiplier.
REQ-010 SHALL have port start  out  1  one-cycle launch pulse to the multiplicador unit.
REQ-011 SHALL have port multiplicando  out  NUM_BITS  operand to multiplier, held stable from start until fin.
REQ-012 SHALL have port multiplicador  out  NUM_BITS  operand to multiplier, held stable from start until fin.
REQ-013 SHALL have port resultado  in  2*NUM_BITS  product from the multiplier.
REQ-014 SHALL have port fin  in  1  multiplier done; only its rising edge is significant.
REQ-015 SHALL have port out_valid  out  1  captured product available.
REQ-016 SHALL have port out_ready  in  1  downstream accepts the product.
REQ-017 SHALL have port out_resultado  out  2*NUM_BITS  captured product.
REQ-018 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-019 Pair SHALL be pushed on a clock edge when in_valid && in_ready; in_ready SHALL be 1 iff FIFO count < FIFO_DEPTH (independent of same-cycle pop).
REQ-020 FSM SHALL have states IDLE, LANZAR, ESPERA, ENTREGA.
REQ-021 IDLE with FIFO nonempty SHALL pop head, register it onto multiplicando/multiplicador, go to LANZAR; IDLE with FIFO empty SHALL stay.
REQ-022 LANZAR SHALL drive start=1 for exactly one cycle, clear the timeout counter, then go to ESPERA.
REQ-023 fin SHALL be registered once; rising edge = fin && !fin_q; edges outside ESPERA SHALL be ignored.
REQ-024 ESPERA on a fin rising edge SHALL capture resultado into out_resultado and go to ENTREGA.
REQ-025 ESPERA without a fin edge for TIMEOUT cycles SHALL set err=1, discard the operation, and return to IDLE.
REQ-026 ENTREGA SHALL hold out_valid=1 and out_resultado stable until out_ready=1, then go to IDLE.
REQ-027 Latency: a pair pushed into an empty FIFO at edge k with the FSM in IDLE SHALL have start high during cycle k+1..k+2.
REQ-028 Products SHALL be delivered in push order; no pair SHALL be lost or duplicated.
REQ-029 err SHALL remain 1 until rst; it SHALL not block further operations.

Reset
REQ-030 rst SHALL immediately force: FSM=IDLE, FIFO empty, in_ready=1, start=0, multiplicando=0, multiplicador=0, out_valid=0, out_resultado=0, err=0, fin_q=0, timeout counter=0.
REQ-031 Reset asserted mid-operation SHALL abandon the in-flight pair and all buffered pairs without any start pulse or out_valid afterward.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and default parameter constants.
REQ-033 The operand buffer SHALL be a separate sub-module fifo_operandos (width 2*NUM_BITS, depth FIFO_DEPTH, push/pop/full/empty/count).

Verification (NUM_BITS=4; bench includes a behavioural multiplier raising fin 5 cycles after start)
REQ-034 Single pair -8 x -8 -> one start pulse, out_resultado=8'h40 (64), out_valid held until out_ready.
REQ-035 Push 5 pairs back-to-back (3x2, -1x7, 7x7, -8x7, 0x-5) -> in_ready=0 after 4th push until first pop; outputs 6, -7, 49, -56, 0 in order.
REQ-036 out_ready held 0 for 20 cycles during ENTREGA -> out_resultado stable, no new start pulse.
REQ-037 Multiplier never raises fin -> err=1 exactly TIMEOUT cycles after start; next pair 2x3 still yields 6.
REQ-038 rst asserted during ESPERA with 3 pairs buffered -> all outputs at reset values next cycle; no further start or out_valid.

Source files
------------

// File: rtl/secuenciador_mult_pkg.sv
// Shared definitions for the multiplier sequencer: FSM encoding and default parameters.
package secuenciador_mult_pkg;

    localparam int unsigned NUM_BITS_DEF   = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LANZAR  = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

endpackage

// File: rtl/secuenciador_mult_fifo_operandos.sv
// First-word-fall-through buffer holding operand pairs awaiting the multiplier.
module fifo_operandos #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/secuenciador_mult.sv
// Buffers operand pairs and sequences them one at a time through an external
// multiplier, returning products in order with a sticky timeout flag.
module secuenciador_mult
    import secuenciador_mult_pkg::*;
#(
    parameter int unsigned NUM_BITS   = NUM_BITS_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_BITS-1:0]   in_multiplicando,
    input  logic [NUM_BITS-1:0]   in_multiplicador,
    output logic                  start,
    output logic [NUM_BITS-1:0]   multiplicando,
    output logic [NUM_BITS-1:0]   multiplicador,
    input  logic [2*NUM_BITS-1:0] resultado,
    input  logic                  fin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NUM_BITS-1:0] out_resultado,
    output logic                  err
);

    localparam int unsigned PAIR_W = 2 * NUM_BITS;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    estado_t           state;
    estado_t           state_d;
    logic [PAIR_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_c;
    logic              pop_c;
    logic              capture_c;
    logic              timeout_c;
    logic              fin_q;
    logic              fin_rise_c;
    logic              tmo_hit_c;
    logic [TMO_W-1:0]  tmo_cnt;

    assign in_ready   = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push_c     = in_valid && !fifo_full;
    assign fin_rise_c = fin && !fin_q;
    // Counter starts one cycle after start, so TIMEOUT-2 lands the flag TIMEOUT cycles after start.
    assign tmo_hit_c  = (state == ESPERA) && (tmo_cnt == TMO_W'(TIMEOUT - 2));

    fifo_operandos #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   ({in_multiplicando, in_multiplicador}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!fifo_empty) state_d = LANZAR;
            LANZAR:  state_d = ESPERA;
            ESPERA:  begin
                if (fin_rise_c)     state_d = ENTREGA;
                else if (tmo_hit_c) state_d = IDLE;
            end
            ENTREGA: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state datapath strobes; a fin edge wins over a coincident timeout.
    always_comb begin
        pop_c     = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state)
            IDLE:    pop_c = !fifo_empty;
            ESPERA:  begin
                if (fin_rise_c)     capture_c = 1'b1;
                else if (tmo_hit_c) timeout_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_q         <= 1'b0;
            start         <= 1'b0;
            out_valid     <= 1'b0;
            multiplicando <= '0;
            multiplicador <= '0;
            out_resultado <= '0;
            err           <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            fin_q     <= fin;
            start     <= (state_d == LANZAR);
            out_valid <= (state_d == ENTREGA);
            if (pop_c) begin
                multiplicando <= fifo_head[PAIR_W-1:NUM_BITS];
                multiplicador <= fifo_head[NUM_BITS-1:0];
            end
            if (capture_c) out_resultado <= resultado;
            if (timeout_c) err <= 1'b1;
            if (state == LANZAR)      tmo_cnt <= '0;
            else if (state == ESPERA) tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_secuenciador_mult.sv
// Directed bench for secuenciador_mult with a behavioural 5-cycle multiplier.
module tb_secuenciador_mult;

    localparam int unsigned NB  = 4;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_multiplicando;
    logic [NB-1:0] in_multiplicador;
    logic          start;
    logic [NB-1:0] multiplicando;
    logic [NB-1:0] multiplicador;
    logic [2*NB-1:0] resultado;
    logic          fin;
    logic          out_valid;
    logic          out_ready;
    logic [2*NB-1:0] out_resultado;
    logic          err;

    int n_checks = 0;
    int n_err    = 0;
    int n_start  = 0;
    int n_outv   = 0;
    int mcnt;
    bit no_fin   = 1'b0;

    always #5 clk = ~clk;

    secuenciador_mult #(
        .NUM_BITS   (NB),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicando (in_multiplicando),
        .in_multiplicador (in_multiplicador),
        .start            (start),
        .multiplicando    (multiplicando),
        .multiplicador    (multiplicador),
        .resultado        (resultado),
        .fin              (fin),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_resultado    (out_resultado),
        .err              (err)
    );

    // Behavioural multiplier: fin rises 5 cycles after start unless suppressed.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fin       <= 1'b0;
            mcnt      <= 0;
            resultado <= '0;
        end else if (start) begin
            fin       <= 1'b0;
            mcnt      <= 5;
            resultado <= 8'($signed(multiplicando) * $signed(multiplicador));
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !no_fin) fin <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (start === 1'b1)     n_start++;
        if (out_valid === 1'b1) n_outv++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [NB-1:0] a, input logic [NB-1:0] b);
        bit done = 1'b0;
        in_valid         = 1'b1;
        in_multiplicando = a;
        in_multiplicador = b;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("push_accepted", 16'(done), 16'd1);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk({tag, "_valid"}, 16'(seen), 16'd1);
        chk(tag, 16'(out_resultado), 16'(exp));
    endtask

    initial begin
        bit stable;
        bit seen;
        int s0;
        int v0;

        rst = 1'b1;
        in_valid = 1'b0;
        in_multiplicando = '0;
        in_multiplicador = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_start", 16'(start), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_out_res", 16'(out_resultado), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single pair -8 x -8, held in ENTREGA with out_ready low
        push(4'h8, 4'h8);
        chk("lat_start_early", 16'(start), 16'd0);
        @(negedge clk);
        chk("lat_start_high", 16'(start), 16'd1);
        chk("op_mcand", 16'(multiplicando), 16'h8);
        @(negedge clk);
        chk("start_one_cycle", 16'(start), 16'd0);
        chk("op_held", 16'({multiplicando, multiplicador}), 16'h88);
        expect_out("res_m8xm8", 8'h40);
        chk("one_start", 16'(n_start), 16'd1);

        // Fill the buffer while the first product waits downstream
        push(4'd3, 4'd2);
        push(4'hF, 4'd7);
        push(4'd7, 4'd7);
        push(4'h8, 4'd7);
        chk("full_in_ready", 16'(in_ready), 16'd0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_resultado !== 8'h40 || out_valid !== 1'b1) stable = 1'b0;
        end
        chk("hold_stable", 16'(stable), 16'd1);
        chk("hold_no_start", 16'(n_start), 16'd1);
        chk("hold_in_ready", 16'(in_ready), 16'd0);

        out_ready = 1'b1;
        push(4'd0, 4'hB);
        expect_out("res_3x2", 8'h06);
        expect_out("res_m1x7", 8'hF9);
        expect_out("res_7x7", 8'h31);
        expect_out("res_m8x7", 8'hC8);
        expect_out("res_0xm5", 8'h00);
        chk("seq_starts", 16'(n_start), 16'd6);

        // Timeout: multiplier never answers
        no_fin = 1'b1;
        push(4'd1, 4'd1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (start) seen = 1'b1;
            else @(negedge clk);
        end
        chk("tmo_start_seen", 16'(seen), 16'd1);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_err_early", 16'(err), 16'd0);
        @(negedge clk);
        chk("tmo_err_set", 16'(err), 16'd1);
        chk("tmo_no_out", 16'(out_valid), 16'd0);
        no_fin = 1'b0;
        push(4'd2, 4'd3);
        expect_out("res_after_tmo", 8'h06);
        chk("err_sticky", 16'(err), 16'd1);

        // Reset during ESPERA with three pairs buffered
        push(4'd1, 4'd2);
        push(4'd3, 4'd3);
        push(4'd2, 4'd2);
        push(4'd5, 4'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_start", 16'(start), 16'd0);
        chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_err", 16'(err), 16'd0);
        chk("mid_rst_ops", 16'({multiplicando, multiplicador}), 16'h00);
        chk("mid_rst_out_res", 16'(out_resultado), 16'd0);
        chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        s0 = n_start;
        v0 = n_outv;
        repeat (30) @(negedge clk);
        chk("post_rst_no_start", 16'(n_start - s0), 16'd0);
        chk("post_rst_no_out", 16'(n_outv - v0), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
